// File: rtl/dp_pkg.sv
// dp_pkg: shared opcodes, FSM encoding and flag positions for datapath_seq
package dp_pkg;
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_MVN = 2'b11;
   localparam logic [1:0] SH_NONE = 2'b00;
   localparam logic [1:0] SH_LSL = 2'b01;
   localparam logic [1:0] SH_LSR = 2'b10;
   localparam logic [1:0] SH_ASR = 2'b11;
   localparam logic [1:0] WS_C = 2'b00;
   localparam logic [1:0] WS_IMM = 2'b01;
   localparam logic [1:0] WS_PC = 2'b10;
   localparam logic [1:0] WS_MEM = 2'b11;
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LDA = 3'd1;
   localparam logic [2:0] S_LDB = 3'd2;
   localparam logic [2:0] S_EXE = 3'd3;
   localparam logic [2:0] S_WB = 3'd4;
   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 2;
endpackage

// File: rtl/datapath_seq_if.sv
// datapath_seq_if: command/response bus between controller and datapath
interface datapath_seq_if #(
   parameter int DATA_W = 16,
   parameter int NREGS = 8,
   parameter int PC_W = 9
);
   localparam int RA_W = $clog2(NREGS);
   logic cmd_valid;
   logic cmd_ready;
   logic [RA_W-1:0] cmd_rn;
   logic [RA_W-1:0] cmd_rm;
   logic [RA_W-1:0] cmd_rd;
   logic [1:0] cmd_aluop;
   logic [1:0] cmd_shift;
   logic cmd_asel;
   logic cmd_bsel;
   logic [1:0] cmd_wsel;
   logic cmd_wb;
   logic cmd_setflags;
   logic [DATA_W-1:0] cmd_imm;
   logic [PC_W-1:0] pc;
   logic [DATA_W-1:0] mdata;
   logic rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic [2:0] flags;
   modport master (
      output cmd_valid, cmd_rn, cmd_rm, cmd_rd, cmd_aluop, cmd_shift, cmd_asel, cmd_bsel,
             cmd_wsel, cmd_wb, cmd_setflags, cmd_imm, pc, mdata,
      input cmd_ready, rsp_valid, rsp_data, flags
   );
   modport slave (
      input cmd_valid, cmd_rn, cmd_rm, cmd_rd, cmd_aluop, cmd_shift, cmd_asel, cmd_bsel,
            cmd_wsel, cmd_wb, cmd_setflags, cmd_imm, pc, mdata,
      output cmd_ready, rsp_valid, rsp_data, flags
   );
endinterface

// File: rtl/dp_regfile.sv
// dp_regfile: general registers, async read, sync write, sync clear
module dp_regfile #(
   parameter int DATA_W = 16,
   parameter int NREGS = 8,
   localparam int RA_W = $clog2(NREGS)
) (
   input logic clk,
   input logic reset,
   input logic we,
   input logic [RA_W-1:0] waddr,
   input logic [DATA_W-1:0] wdata,
   input logic [RA_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] regs [NREGS];
   // clear everything on reset, otherwise single write port
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end
   assign rdata = regs[raddr];
endmodule

// File: rtl/datapath_seq.sv
// datapath_seq: sequenced datapath, one command = read A, read B, execute, writeback
module datapath_seq
   import dp_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NREGS = 8,
   parameter int PC_W = 9
) (
   input logic clk,
   input logic reset,
   datapath_seq_if.slave bus
);
   localparam int RA_W = $clog2(NREGS);
   localparam int M = DATA_W - 1;
   logic [2:0] state;
   logic [RA_W-1:0] rn, rm, rd, raddr;
   logic [1:0] aluop, shift, wsel;
   logic asel, bsel, wb, setflags, rsp_q, ovf, accept;
   logic [DATA_W-1:0] imm, a, b, c, rdata, b_sh, ain, bin, res, wdata;
   logic [PC_W-1:0] pc_q;
   logic [2:0] flags_q;
   assign accept = state == S_IDLE && bus.cmd_valid;
   // shifter, ALU, overflow and writeback selection
   always_comb begin
      raddr = state == S_LDA ? rn : rm;
      b_sh = shift == SH_LSL ? {b[M-1:0], 1'b0} :
             shift == SH_LSR ? {1'b0, b[M:1]} :
             shift == SH_ASR ? {b[M], b[M:1]} : b;
      ain = asel ? '0 : a;
      bin = bsel ? imm : b_sh;
      res = aluop == ALU_ADD ? ain + bin :
            aluop == ALU_SUB ? ain - bin :
            aluop == ALU_AND ? ain & bin : ~bin;
      ovf = aluop == ALU_ADD ? (ain[M] == bin[M]) && (res[M] != ain[M]) :
            aluop == ALU_SUB ? (ain[M] != bin[M]) && (res[M] != ain[M]) : 1'b0;
      wdata = wsel == WS_C ? c :
              wsel == WS_IMM ? imm :
              wsel == WS_PC ? DATA_W'(pc_q) : bus.mdata;
   end
   // latch the whole command on accept so later bus changes are ignored
   always_ff @(posedge clk) begin
      if (reset) begin
         {rn, rm, rd, aluop, shift, asel, bsel, wsel, wb, setflags} <= '0;
         imm <= '0;
         pc_q <= '0;
      end else if (accept) begin
         {rn, rm, rd} <= {bus.cmd_rn, bus.cmd_rm, bus.cmd_rd};
         {aluop, shift, asel, bsel} <= {bus.cmd_aluop, bus.cmd_shift, bus.cmd_asel, bus.cmd_bsel};
         {wsel, wb, setflags} <= {bus.cmd_wsel, bus.cmd_wb, bus.cmd_setflags};
         imm <= bus.cmd_imm;
         pc_q <= bus.pc;
      end
   end
   // micro-sequencer with operand, result and status registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         {a, b, c} <= '0;
         flags_q <= '0;
         rsp_q <= 1'b0;
      end else begin
         rsp_q <= state == S_WB;
         state <= accept ? S_LDA :
                  state == S_LDA ? S_LDB :
                  state == S_LDB ? S_EXE :
                  state == S_EXE ? S_WB : S_IDLE;
         if (state == S_LDA) a <= rdata;
         if (state == S_LDB) b <= rdata;
         if (state == S_EXE) c <= res;
         if (state == S_EXE && setflags) begin
            flags_q[FLAG_V] <= ovf;
            flags_q[FLAG_N] <= res[M];
            flags_q[FLAG_Z] <= res == '0;
         end
      end
   end
   dp_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
      .clk(clk),
      .reset(reset),
      .we(state == S_WB && wb),
      .waddr(rd),
      .wdata(wdata),
      .raddr(raddr),
      .rdata(rdata)
   );
   assign bus.cmd_ready = state == S_IDLE;
   assign bus.rsp_valid = rsp_q;
   assign bus.rsp_data = c;
   assign bus.flags = flags_q;
endmodule

// File: tb/tb_datapath_seq.sv
// tb_datapath_seq: scoreboard bench for the sequenced datapath
module tb_datapath_seq;
   import dp_pkg::*;
   typedef struct packed {
      logic [15:0] d;
      logic [2:0] f;
   } rsp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_chk = 0;
   int n_fail = 0;
   logic [2:0] cur_f = 3'b000;
   rsp_t exp_q[$];
   rsp_t obs_q[$];
   datapath_seq_if #(.DATA_W(16), .NREGS(8), .PC_W(9)) bus ();
   datapath_seq #(.DATA_W(16), .NREGS(8), .PC_W(9)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   // collect every response pulse
   always @(negedge clk) if (bus.rsp_valid === 1'b1) obs_q.push_back({bus.rsp_data, bus.flags});
   task automatic drive(input logic [2:0] rn, rm, rd, input logic [1:0] op, sh, ws,
                        input logic as, bs, wb, sf, input logic [15:0] imm, input logic [8:0] pcv);
      bus.cmd_rn = rn; bus.cmd_rm = rm; bus.cmd_rd = rd;
      bus.cmd_aluop = op; bus.cmd_shift = sh; bus.cmd_wsel = ws;
      bus.cmd_asel = as; bus.cmd_bsel = bs; bus.cmd_wb = wb; bus.cmd_setflags = sf;
      bus.cmd_imm = imm; bus.pc = pcv;
   endtask
   task automatic issue(input logic [2:0] rn, rm, rd, input logic [1:0] op, sh, ws,
                        input logic as, bs, wb, sf, input logic [15:0] imm, input logic [8:0] pcv,
                        input logic [15:0] ed, input logic [2:0] ef, output int lat);
      int k, n0;
      k = 0;
      while (bus.cmd_ready !== 1'b1 && k < 20) begin @(negedge clk); #1; k++; end
      drive(rn, rm, rd, op, sh, ws, as, bs, wb, sf, imm, pcv);
      bus.cmd_valid = 1'b1;
      exp_q.push_back({ed, ef});
      n0 = obs_q.size();
      @(posedge clk); @(negedge clk); #1;
      bus.cmd_valid = 1'b0;
      lat = 1;
      while (obs_q.size() == n0 && lat < 20) begin @(negedge clk); #1; lat++; end
   endtask
   task automatic peek(input logic [2:0] r, input logic [15:0] ev, output int lat);
      issue(3'd0, r, 3'd0, ALU_ADD, SH_NONE, WS_C, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 9'h0, ev, cur_f, lat);
   endtask
   task automatic pop(output rsp_t e, output rsp_t o, output bit ok);
      ok = exp_q.size() > 0 && obs_q.size() > 0;
      e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
      o = obs_q.size() > 0 ? obs_q.pop_front() : '0;
   endtask
   task automatic preload(input logic [2:0] r, input logic [15:0] v);
      int lat;
      rsp_t e, o;
      bit ok;
      issue(3'd0, 3'd0, r, ALU_ADD, SH_NONE, WS_IMM, 1'b1, 1'b1, 1'b1, 1'b0, v, 9'h0, v, cur_f, lat);
      pop(e, o, ok);
   endtask
   task automatic test_reset;
      bus.cmd_valid = 1'b0;
      drive(3'd0, 3'd0, 3'd0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 9'h0);
      bus.mdata = 16'h0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk); #1;
      n_chk++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready); end
      n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
      n_chk++; if (bus.rsp_data !== 16'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0000", bus.rsp_data); end
      n_chk++; if (bus.flags !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", bus.flags); end
   endtask
   task automatic test_add;
      int lat;
      rsp_t e, o;
      bit ok;
      preload(3'd1, 16'h0005);
      preload(3'd2, 16'h0003);
      issue(3'd1, 3'd2, 3'd3, ALU_ADD, SH_NONE, WS_C, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 9'h0, 16'h0008, 3'b000, lat);
      cur_f = 3'b000;
      pop(e, o, ok);
      n_chk++; if (lat != 5) begin n_fail++; $display("FAIL add_latency: got %0d want 5", lat); end
      n_chk++; if (!ok || o.d !== e.d) begin n_fail++; $display("FAIL add_data: got %h want %h", o.d, e.d); end
      n_chk++; if (!ok || o.f !== e.f) begin n_fail++; $display("FAIL add_flags: got %b want %b", o.f, e.f); end
      peek(3'd3, 16'h0008, lat);
      pop(e, o, ok);
      n_chk++; if (!ok || o.d !== e.d) begin n_fail++; $display("FAIL add_r3: got %h want %h", o.d, e.d); end
   endtask
   task automatic test_flags;
      int lat;
      rsp_t e, o;
      bit ok;
      issue(3'd1, 3'd1, 3'd7, ALU_AND, SH_NONE, WS_C, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 9'h0, 16'h0005, 3'b000, lat);
      pop(e, o, ok);
      n_chk++; if (!ok || o !== e) begin n_fail++; $display("FAIL and_rsp: got %h/%b want %h/%b", o.d, o.f, e.d, e.f); end
      issue(3'd1, 3'd1, 3'd7, ALU_SUB, SH_NONE, WS_C, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 9'h0, 16'h0000, 3'b001, lat);
      cur_f = 3'b001;
      pop(e, o, ok);
      n_chk++; if (!ok || o !== e) begin n_fail++; $display("FAIL sub_zero: got %h/%b want %h/%b", o.d, o.f, e.d, e.f); end
      preload(3'd1, 16'h7FFF);
      preload(3'd2, 16'h0001);
      issue(3'd1, 3'd2, 3'd3, ALU_ADD, SH_NONE, WS_C, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 9'h0, 16'h8000, 3'b110, lat);
      cur_f = 3'b110;
      pop(e, o, ok);
      n_chk++; if (!ok || o !== e) begin n_fail++; $display("FAIL add_overflow: got %h/%b want %h/%b", o.d, o.f, e.d, e.f); end
   endtask
   task automatic test_shift;
      int lat;
      rsp_t e, o;
      bit ok;
      logic [1:0] shs [4] = '{SH_ASR, SH_LSR, SH_LSL, SH_NONE};
      logic [15:0] bexp [4] = '{16'hC000, 16'h4000, 16'h0002, 16'h8001};
      preload(3'd2, 16'h8001);
      for (int i = 0; i < 4; i++) begin
         issue(3'd0, 3'd2, 3'd0, ALU_ADD, shs[i], WS_C, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 9'h0, bexp[i], cur_f, lat);
         pop(e, o, ok);
         n_chk++; if (!ok || o !== e) begin n_fail++; $display("FAIL shift_%0d: got %h/%b want %h/%b", i, o.d, o.f, e.d, e.f); end
      end
      issue(3'd0, 3'd2, 3'd0, ALU_MVN, SH_ASR, WS_C, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 9'h0, 16'h3FFF, cur_f, lat);
      pop(e, o, ok);
      n_chk++; if (!ok || o !== e) begin n_fail++; $display("FAIL mvn_asr: got %h want %h", o.d, e.d); end
      issue(3'd0, 3'd2, 3'd0, ALU_ADD, SH_LSL, WS_C, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 9'h0, 16'h1234, cur_f, lat);
      pop(e, o, ok);
      n_chk++; if (!ok || o !== e) begin n_fail++; $display("FAIL bsel_bypass: got %h want %h", o.d, e.d); end
   endtask
   task automatic test_wsel;
      int lat;
      rsp_t e, o;
      bit ok;
      issue(3'd0, 3'd0, 3'd4, ALU_ADD, SH_NONE, WS_PC, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 9'h1A5, 16'h0000, cur_f, lat);
      pop(e, o, ok);
      peek(3'd4, 16'h01A5, lat);
      pop(e, o, ok);
      n_chk++; if (!ok || o.d !== e.d) begin n_fail++; $display("FAIL wsel_pc: got %h want %h", o.d, e.d); end
      bus.mdata = 16'hBEEF;
      issue(3'd0, 3'd0, 3'd5, ALU_ADD, SH_NONE, WS_MEM, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 9'h0, 16'h0000, cur_f, lat);
      bus.mdata = 16'h0;
      pop(e, o, ok);
      peek(3'd5, 16'hBEEF, lat);
      pop(e, o, ok);
      n_chk++; if (!ok || o.d !== e.d) begin n_fail++; $display("FAIL wsel_mem: got %h want %h", o.d, e.d); end
      issue(3'd4, 3'd5, 3'd6, ALU_ADD, SH_NONE, WS_C, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 9'h0, 16'hC094, cur_f, lat);
      pop(e, o, ok);
      peek(3'd6, 16'hC094, lat);
      pop(e, o, ok);
      n_chk++; if (!ok || o.d !== e.d) begin n_fail++; $display("FAIL wsel_c: got %h want %h", o.d, e.d); end
      issue(3'd0, 3'd0, 3'd4, ALU_ADD, SH_NONE, WS_IMM, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 9'h0, 16'hFFFF, cur_f, lat);
      pop(e, o, ok);
      peek(3'd4, 16'h01A5, lat);
      pop(e, o, ok);
      n_chk++; if (!ok || o.d !== e.d) begin n_fail++; $display("FAIL wb_off: got %h want %h", o.d, e.d); end
      issue(3'd5, 3'd5, 3'd5, ALU_ADD, SH_NONE, WS_C, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 9'h0, 16'h7DDE, cur_f, lat);
      pop(e, o, ok);
      n_chk++; if (!ok || o.d !== e.d) begin n_fail++; $display("FAIL same_reg: got %h want %h", o.d, e.d); end
      peek(3'd5, 16'h7DDE, lat);
      pop(e, o, ok);
      n_chk++; if (!ok || o.d !== e.d) begin n_fail++; $display("FAIL same_reg_wb: got %h want %h", o.d, e.d); end
   endtask
   task automatic test_back_to_back;
      int acc, low, last, gap_bad, k;
      rsp_t e, o;
      bit ok;
      acc = 0; low = 0; last = -1; gap_bad = 0;
      for (int i = 0; i < 3; i++) exp_q.push_back({16'h7FFF, cur_f});
      bus.cmd_valid = 1'b1;
      for (int c = 0; c < 15; c++) begin
         if (bus.cmd_ready === 1'b1) begin
            drive(3'd0, 3'd1, 3'd0, ALU_ADD, SH_NONE, WS_C, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 9'h0);
            if (last >= 0 && c - last != 5) gap_bad++;
            last = c;
            acc++;
         end else begin
            low++;
            drive(3'd3, 3'd2, 3'd1, ALU_SUB, SH_LSL, WS_IMM, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0, 9'h0);
         end
         @(negedge clk); #1;
      end
      bus.cmd_valid = 1'b0;
      k = 0;
      while (obs_q.size() < 3 && k < 20) begin @(negedge clk); #1; k++; end
      n_chk++; if (acc != 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 3", acc); end
      n_chk++; if (low != 12) begin n_fail++; $display("FAIL b2b_ready_low: got %0d want 12", low); end
      n_chk++; if (gap_bad != 0) begin n_fail++; $display("FAIL b2b_spacing: got %0d bad gaps want 0", gap_bad); end
      for (int i = 0; i < 3; i++) begin
         pop(e, o, ok);
         n_chk++; if (!ok || o !== e) begin n_fail++; $display("FAIL b2b_rsp_%0d: got %h/%b want %h/%b", i, o.d, o.f, e.d, e.f); end
      end
   endtask
   task automatic test_reset_abort;
      int lat, n0;
      rsp_t e, o;
      bit ok;
      preload(3'd4, 16'h1234);
      drive(3'd0, 3'd0, 3'd4, ALU_ADD, SH_NONE, WS_IMM, 1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF, 9'h0);
      bus.cmd_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      n0 = obs_q.size();
      drive(3'd0, 3'd4, 3'd0, ALU_ADD, SH_NONE, WS_C, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 9'h0);
      bus.cmd_valid = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      bus.cmd_valid = 1'b0;
      #1;
      n_chk++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", bus.cmd_ready); end
      n_chk++; if (bus.flags !== 3'b000) begin n_fail++; $display("FAIL abort_flags: got %b want 000", bus.flags); end
      n_chk++; if (bus.rsp_data !== 16'h0) begin n_fail++; $display("FAIL abort_rsp_data: got %h want 0000", bus.rsp_data); end
      repeat (8) @(negedge clk);
      #1;
      n_chk++; if (obs_q.size() != n0) begin n_fail++; $display("FAIL abort_no_rsp: got %0d responses want 0", obs_q.size() - n0); end
      cur_f = 3'b000;
      peek(3'd4, 16'h0000, lat);
      pop(e, o, ok);
      n_chk++; if (!ok || o !== e) begin n_fail++; $display("FAIL abort_r4: got %h/%b want %h/%b", o.d, o.f, e.d, e.f); end
   endtask
   initial begin
      test_reset();
      test_add();
      test_flags();
      test_shift();
      test_wsel();
      test_back_to_back();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
